prescaled_bcd_timer: RTL and testbench

//  Downstream consumer of the clock prescaler's divided output (outCLK).
//  - Synchronises that slow square wave into the system clock domain.
//  - Converts each rising edge into a one-cycle tick.
//  - Drives a DIGITS-wide BCD up-counter (stopwatch/seconds counter) with start/stop/clear control.
//  - Output feeds the 7-segment display driver.

---
 rtl/prescaled_bcd_timer_pkg.sv | 26 ++
 rtl/prescaled_bcd_timer_bcd_digit.sv | 43 ++++
 rtl/prescaled_bcd_timer.sv | 138 +++++++++++++
 tb/tb_prescaled_bcd_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// Package  : prescaler_pkg
// Purpose  : Shared types and constants for the prescaled BCD timer.
// Revision : 1.0 - initial release
// ============================================================================
package prescaler_pkg;

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX             = 4'd9;
    localparam int         DEFAULT_SYNC_STAGES = 2;
    localparam int         ARM_CYCLES          = DEFAULT_SYNC_STAGES + 1;

    // Arming window for an arbitrary synchroniser depth
    function automatic int arm_cycles(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prescaled_bcd_timer_bcd_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Purpose  : One decade of the BCD counter; rolls 9 -> 0 with combinational carry.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
    import prescaler_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       carry
);

    bcd_digit_t q_d;
    bcd_digit_t q_q;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            // >= keeps the digit inside 0..9 even from an unexpected state
            q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign carry = inc & (q_q == BCD_MAX);

endmodule
`default_nettype wire

// File: rtl/prescaled_bcd_timer.sv
`default_nettype none
// ============================================================================
// Module   : prescaled_bcd_timer
// Purpose  : Synchronises prescaler outCLK, makes one tick per rise and drives
//            a start/stop/clear BCD up-counter. Optional macro: ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prescaled_bcd_timer
    import prescaler_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  slowClk,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
`ifdef ALARM_EN
    input  logic [4*DIGITS-1:0]   alarmValue,
    output logic                  alarm,
`endif
    output logic                  tick,
    output logic                  running,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  wrap
);

    localparam int ARM   = arm_cycles(SYNC_STAGES);
    localparam int ARM_W = $clog2(ARM + 1);

    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_d;
    logic                   prev_q;
    logic [ARM_W-1:0]       arm_cnt_d;
    logic [ARM_W-1:0]       arm_cnt_q;
    logic                   tick_d;
    logic                   tick_q;
    timer_state_t           state_d;
    timer_state_t           state_q;
    logic                   wrap_d;
    logic                   wrap_q;
    logic                   sync_out;
    logic                   armed;
    logic [DIGITS-1:0]      dig_inc;
    logic [DIGITS-1:0]      dig_carry;

    // Synchroniser, arming window and rising-edge detector
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], slowClk};
        sync_out  = sync_q[SYNC_STAGES-1];
        prev_d    = sync_out;
        armed     = (arm_cnt_q == ARM_W'(ARM));
        arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 1'b1;
        tick_d    = armed & sync_out & ~prev_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOPPED: if (start && !stop) state_d = ST_RUNNING;
            ST_RUNNING: if (stop)           state_d = ST_STOPPED;
            default:                        state_d = ST_STOPPED;
        endcase
    end

    // Digit 0 counts on the combinational tick so bcd moves on the tick edge
    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            if (i == 0) begin : g_lsb
                assign dig_inc[i] = tick_d & (state_q == ST_RUNNING);
            end else begin : g_chain
                assign dig_inc[i] = dig_carry[i-1];
            end

            bcd_digit u_digit (
                .clock (clock),
                .reset (reset),
                .clr   (clear),
                .inc   (dig_inc[i]),
                .q     (bcd[4*i +: 4]),
                .carry (dig_carry[i])
            );
        end
    endgenerate

    always_comb begin
        wrap_d = dig_carry[DIGITS-1] & ~clear;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            arm_cnt_q <= '0;
            tick_q    <= 1'b0;
            state_q   <= ST_STOPPED;
            wrap_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
            tick_q    <= tick_d;
            state_q   <= state_d;
            wrap_q    <= wrap_d;
        end
    end

`ifdef ALARM_EN
    logic alarm_d;
    logic alarm_q;

    always_comb begin
        alarm_d = alarm_q | ((state_q == ST_RUNNING) && (bcd == alarmValue));
        if (clear) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`endif

    assign tick    = tick_q;
    assign running = (state_q == ST_RUNNING);
    assign wrap    = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_bcd_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prescaled_bcd_timer
// Purpose  : Scoreboard bench for prescaled_bcd_timer (DIGITS=4, SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prescaled_bcd_timer;

    localparam int DIGITS      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int LAT         = SYNC_STAGES + 1;

    typedef struct {
        int          cyc;
        logic [15:0] bcd;
        logic        wrap;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        slowClk = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        tick;
    logic        running;
    logic [15:0] bcd;
    logic        wrap;
`ifdef ALARM_EN
    logic [15:0] alarmValue = 16'h0005;
    logic        alarm;
`endif

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   model_count = 0;
    bit   model_running = 0;
    exp_t sb[$];
    exp_t mon_e;

    prescaled_bcd_timer #(
        .DIGITS      (DIGITS),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .slowClk    (slowClk),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
`ifdef ALARM_EN
        .alarmValue (alarmValue),
        .alarm      (alarm),
`endif
        .tick       (tick),
        .running    (running),
        .bcd        (bcd),
        .wrap       (wrap)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          v;
        v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // One slowClk rise: high for hi cycles, low for lo cycles; optional clear on the tick edge
    task automatic do_rise(input int hi, input int lo, input bit clr_at_tick);
        exp_t e;
        @(negedge clock);
        slowClk = 1'b1;
        e.wrap = 1'b0;
        if (clr_at_tick) begin
            model_count = 0;
        end else if (model_running) begin
            e.wrap      = (model_count == 9999);
            model_count = (model_count + 1) % 10000;
        end
        e.cyc = cyc + LAT;
        e.bcd = to_bcd(model_count);
        sb.push_back(e);
        for (int i = 1; i <= hi + lo; i++) begin
            @(negedge clock);
            clear = (clr_at_tick && i == LAT - 1);
            if (i == hi) slowClk = 1'b0;
        end
        clear = 1'b0;
    endtask

    // Scoreboard monitor: expected ticks popped on their due cycle, silence otherwise
    always @(negedge clock) begin
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            check_eq("tick", tick, 1);
            check_eq("tick_bcd", bcd, mon_e.bcd);
            check_eq("tick_wrap", wrap, mon_e.wrap);
        end else begin
            check_eq("no_tick", tick, 0);
            check_eq("no_wrap", wrap, 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: slowClk high across reset release must not tick
        repeat (3) @(negedge clock);
        check_eq("rst_bcd", bcd, 0);
        check_eq("rst_running", running, 0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check_eq("arm_bcd", bcd, 0);
        check_eq("arm_running", running, 0);
        slowClk = 1'b0;
        repeat (4) @(negedge clock);

        // 2: start pulse, three slow rises
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        model_running = 1;
        check_eq("start_running", running, 1);
        repeat (3) do_rise(4, 4, 0);
        check_eq("three_ticks_bcd", bcd, 16'h0003);

        // 3: run up to 9999 then roll over
        while (model_count != 9999) do_rise(1, 1, 0);
        repeat (4) @(negedge clock);
        check_eq("preload_bcd", bcd, 16'h9999);
        do_rise(4, 4, 0);
        check_eq("after_wrap_bcd", bcd, 16'h0000);

        // 4: clear coincident with a tick at 0041
        repeat (41) do_rise(1, 1, 0);
        repeat (4) @(negedge clock);
        check_eq("pre_clear_bcd", bcd, 16'h0041);
        do_rise(4, 4, 1);
        check_eq("clear_bcd", bcd, 16'h0000);
        check_eq("clear_running", running, 1);
        do_rise(4, 4, 0);
        check_eq("post_clear_bcd", bcd, 16'h0001);

        // 5: start and stop together, stop wins
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        model_running = 0;
        check_eq("stop_wins_running", running, 0);
        do_rise(4, 4, 0);
        check_eq("stopped_bcd", bcd, 16'h0001);

`ifdef ALARM_EN
        // 6: alarm at 0005, sticky until clear
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_count = 0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        model_running = 1;
        check_eq("alarm_start_clr", alarm, 0);
        repeat (4) do_rise(4, 4, 0);
        check_eq("alarm_before", alarm, 0);
        do_rise(4, 4, 0);
        check_eq("alarm_set", alarm, 1);
        repeat (2) do_rise(4, 4, 0);
        check_eq("alarm_bcd7", bcd, 16'h0007);
        check_eq("alarm_sticky", alarm, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        model_count = 0;
        @(negedge clock);
        check_eq("alarm_cleared", alarm, 0);
        check_eq("alarm_clear_bcd", bcd, 16'h0000);
`endif

        repeat (10) @(negedge clock);
        check_eq("sb_drain", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
